// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipeline control path: opcodes, control bundle,
// per-stage register layouts and operand-forwarding select encodings.
package ctrl_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned AOP_W  = 2;
  localparam int unsigned CTRL_W = 9;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic             regDst;
    logic             aluSrc;
    logic             memToReg;
    logic             regWrite;
    logic             memRead;
    logic             memWrite;
    logic             branch;
    logic [AOP_W-1:0] aluOp;
  } ctrlBundle_t;

  localparam ctrlBundle_t CTRL_BUBBLE = ctrlBundle_t'(CTRL_W'(0));

  typedef struct packed {
    logic              valid;
    ctrlBundle_t       ctrl;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } exStage_t;

  typedef struct packed {
    logic              memToReg;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              branch;
    logic [REG_AW-1:0] dest;
  } memStage_t;

  typedef struct packed {
    logic              memToReg;
    logic              regWrite;
    logic [REG_AW-1:0] dest;
  } wbStage_t;

  // Youngest producer wins; $0 is never a forwarding source.
  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] src,
    input logic              memRegWrite,
    input logic [REG_AW-1:0] memDest,
    input logic              wbRegWrite,
    input logic [REG_AW-1:0] wbDest
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (memRegWrite && (memDest != REG_AW'(0)) && (memDest == src)) begin
      sel = FWD_MEM;
    end else if (wbRegWrite && (wbDest != REG_AW'(0)) && (wbDest == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ctrl_pipeline_fwd_unit.sv
// EX-stage operand source selects derived from the MEM and WB stage destinations.
module fwd_unit
  import ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] exRs,
  input  logic [REG_AW-1:0] exRt,
  input  logic              memRegWrite,
  input  logic [REG_AW-1:0] memDest,
  input  logic              wbRegWrite,
  input  logic [REG_AW-1:0] wbDest,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB
);

  assign fwdA = fwdSel(exRs, memRegWrite, memDest, wbRegWrite, wbDest);
  assign fwdB = fwdSel(exRt, memRegWrite, memDest, wbRegWrite, wbDest);

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries decoded control bits from ID through EX, MEM and WB, inserting bubbles on
// load-use hazards and branch flush, and drives the EX forwarding selects.
module ctrl_pipeline
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_regdst,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic [AOP_W-1:0]  id_aluop,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic              stall,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic [AOP_W-1:0]  ex_aluop,
  output logic [REG_AW-1:0] ex_dest,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_branch,
  output logic [REG_AW-1:0] mem_dest,
  output logic              wb_memtoreg,
  output logic              wb_regwrite,
  output logic [REG_AW-1:0] wb_dest,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  exStage_t  exQ,  exD;
  memStage_t memQ, memD;
  wbStage_t  wbQ,  wbD;

  // Load-use hazard against the instruction currently in EX; flush wins.
  assign stall = exQ.valid & exQ.ctrl.memRead & (exQ.dest != REG_AW'(0)) &
                 ((exQ.dest == id_rs) | (exQ.dest == id_rt)) & id_valid & ~flush;

  always_comb begin
    exD = '0;
    if (!flush && !stall && id_valid) begin
      exD.valid         = 1'b1;
      exD.ctrl.regDst   = id_regdst;
      exD.ctrl.aluSrc   = id_alusrc;
      exD.ctrl.memToReg = id_memtoreg;
      exD.ctrl.regWrite = id_regwrite;
      exD.ctrl.memRead  = id_memread;
      exD.ctrl.memWrite = id_memwrite;
      exD.ctrl.branch   = id_branch;
      exD.ctrl.aluOp    = id_aluop;
      exD.dest          = id_regdst ? id_rd : id_rt;
      exD.rs            = id_rs;
      exD.rt            = id_rt;
    end

    memD = '0;
    if (!flush) begin
      memD.memToReg = exQ.ctrl.memToReg;
      memD.regWrite = exQ.ctrl.regWrite;
      memD.memRead  = exQ.ctrl.memRead;
      memD.memWrite = exQ.ctrl.memWrite;
      memD.branch   = exQ.ctrl.branch;
      memD.dest     = exQ.dest;
    end

    // A flushing branch in MEM still retires; it carries regWrite=0.
    wbD          = '0;
    wbD.memToReg = memQ.memToReg;
    wbD.regWrite = memQ.regWrite;
    wbD.dest     = memQ.dest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exQ  <= '0;
      memQ <= '0;
      wbQ  <= '0;
    end else begin
      exQ  <= exD;
      memQ <= memD;
      wbQ  <= wbD;
    end
  end

  assign ex_regdst    = exQ.ctrl.regDst;
  assign ex_alusrc    = exQ.ctrl.aluSrc;
  assign ex_aluop     = exQ.ctrl.aluOp;
  assign ex_dest      = exQ.dest;
  assign mem_memread  = memQ.memRead;
  assign mem_memwrite = memQ.memWrite;
  assign mem_branch   = memQ.branch;
  assign mem_dest     = memQ.dest;
  assign wb_memtoreg  = wbQ.memToReg;
  assign wb_regwrite  = wbQ.regWrite;
  assign wb_dest      = wbQ.dest;

  fwd_unit uFwd (
    .exRs        (exQ.rs),
    .exRt        (exQ.rt),
    .memRegWrite (memQ.regWrite),
    .memDest     (memQ.dest),
    .wbRegWrite  (wbQ.regWrite),
    .wbDest      (wbQ.dest),
    .fwdA        (fwd_a),
    .fwdB        (fwd_b)
  );

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: reset, load-use stall, forwarding, $0, flush, propagation.
module tb_ctrl_pipeline;

  logic       clk;
  logic       rst;
  logic       id_valid, id_regdst, id_alusrc, id_memtoreg, id_regwrite;
  logic       id_memread, id_memwrite, id_branch;
  logic [1:0] id_aluop;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       flush;
  logic       stall;
  logic       ex_regdst, ex_alusrc;
  logic [1:0] ex_aluop;
  logic [4:0] ex_dest;
  logic       mem_memread, mem_memwrite, mem_branch;
  logic [4:0] mem_dest;
  logic       wb_memtoreg, wb_regwrite;
  logic [4:0] wb_dest;
  logic [1:0] fwd_a, fwd_b;

  int checks   = 0;
  int failures = 0;

  // Bundle order {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, AluOP}
  localparam logic [8:0] LW_B   = 9'b011110_0_00;
  localparam logic [8:0] ADD_B  = 9'b100100_0_10;
  localparam logic [8:0] ADDI_B = 9'b010100_0_00;
  localparam logic [8:0] BEQ_B  = 9'b000000_1_01;
  localparam logic [8:0] SW_B   = 9'bx1x001_0_00;

  logic [28:0] allOut;
  assign allOut = {ex_regdst, ex_alusrc, ex_aluop, ex_dest, mem_memread, mem_memwrite,
                   mem_branch, mem_dest, wb_memtoreg, wb_regwrite, wb_dest, stall,
                   fwd_a, fwd_b};

  ctrl_pipeline dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_regdst    (id_regdst),
    .id_alusrc    (id_alusrc),
    .id_memtoreg  (id_memtoreg),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_memwrite  (id_memwrite),
    .id_branch    (id_branch),
    .id_aluop     (id_aluop),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .flush        (flush),
    .stall        (stall),
    .ex_regdst    (ex_regdst),
    .ex_alusrc    (ex_alusrc),
    .ex_aluop     (ex_aluop),
    .ex_dest      (ex_dest),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .mem_branch   (mem_branch),
    .mem_dest     (mem_dest),
    .wb_memtoreg  (wb_memtoreg),
    .wb_regwrite  (wb_regwrite),
    .wb_dest      (wb_dest),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setId(input logic v, input logic [8:0] b,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid    = v;
    id_regdst   = b[8];
    id_alusrc   = b[7];
    id_memtoreg = b[6];
    id_regwrite = b[5];
    id_memread  = b[4];
    id_memwrite = b[3];
    id_branch   = b[2];
    id_aluop    = b[1:0];
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    setId(1'b1, LW_B, 5'd1, 5'd8, 5'd0);

    // Reset held two cycles with a live lw at ID
    tick();
    chk("reset_c1_all", 32'(allOut), 0);
    tick();
    chk("reset_c2_all", 32'(allOut), 0);
    rst = 1'b0;
    #1;
    chk("reset_rel_stall", 32'(stall), 0);

    // lw enters EX on the first edge after release
    tick();
    chk("lw_ex_alusrc", 32'(ex_alusrc), 1);
    chk("lw_ex_regdst", 32'(ex_regdst), 0);
    chk("lw_ex_dest", 32'(ex_dest), 8);

    // Load-use: add $10,$8,$9 behind lw $8
    setId(1'b1, ADD_B, 5'd8, 5'd9, 5'd10);
    chk("lu_stall_on", 32'(stall), 1);
    tick();
    chk("lu_ex_bubble_dest", 32'(ex_dest), 0);
    chk("lu_ex_bubble_aluop", 32'(ex_aluop), 0);
    chk("lu_mem_memread", 32'(mem_memread), 1);
    chk("lu_mem_dest", 32'(mem_dest), 8);
    chk("lu_stall_off", 32'(stall), 0);
    tick();
    chk("lu_add_ex_dest", 32'(ex_dest), 10);
    chk("lu_add_ex_aluop", 32'(ex_aluop), 2);
    chk("lu_fwd_a", 32'(fwd_a), 1);
    chk("lu_fwd_b", 32'(fwd_b), 0);
    chk("lu_wb_lw", 32'({wb_memtoreg, wb_regwrite, wb_dest}), 32'h68);

    // EX-to-EX: add $3 then sub using rt=$3
    setId(1'b1, ADD_B, 5'd1, 5'd2, 5'd3);
    tick();
    setId(1'b1, ADD_B, 5'd4, 5'd3, 5'd5);
    chk("ex2ex_stall", 32'(stall), 0);
    tick();
    chk("ex2ex_fwd_b", 32'(fwd_b), 2);
    chk("ex2ex_fwd_a", 32'(fwd_a), 0);

    // One nop between producer $6 and consumer
    setId(1'b1, ADD_B, 5'd1, 5'd2, 5'd6);
    tick();
    setId(1'b0, ADD_B, 5'd6, 5'd6, 5'd6);
    tick();
    setId(1'b1, ADD_B, 5'd7, 5'd6, 5'd17);
    tick();
    chk("gap_fwd_b", 32'(fwd_b), 1);
    chk("gap_fwd_a", 32'(fwd_a), 0);

    // MEM and WB both write $11: MEM wins
    setId(1'b1, ADD_B, 5'd1, 5'd2, 5'd11);
    tick();
    tick();
    setId(1'b1, ADD_B, 5'd11, 5'd11, 5'd18);
    tick();
    chk("prio_fwd_a", 32'(fwd_a), 2);
    chk("prio_fwd_b", 32'(fwd_b), 2);

    // $0 destination never forwards or stalls
    setId(1'b1, ADDI_B, 5'd1, 5'd0, 5'd0);
    tick();
    setId(1'b1, ADD_B, 5'd0, 5'd0, 5'd12);
    tick();
    chk("z0_addi_fwd", 32'({fwd_a, fwd_b}), 0);
    chk("z0_ex_dest", 32'(ex_dest), 12);
    setId(1'b1, LW_B, 5'd0, 5'd0, 5'd0);
    tick();
    setId(1'b1, ADD_B, 5'd0, 5'd0, 5'd13);
    chk("z0_lw_stall", 32'(stall), 0);
    tick();
    chk("z0_lw_ex_dest", 32'(ex_dest), 13);
    chk("z0_lw_fwd", 32'({fwd_a, fwd_b}), 0);

    // Flush vs stall: beq in MEM, lw in EX, dependent add at ID
    setId(1'b1, BEQ_B, 5'd1, 5'd2, 5'd0);
    tick();
    setId(1'b1, LW_B, 5'd1, 5'd14, 5'd0);
    tick();
    chk("fl_mem_branch", 32'(mem_branch), 1);
    setId(1'b1, ADD_B, 5'd14, 5'd0, 5'd15);
    chk("fl_stall_pre", 32'(stall), 1);
    flush = 1'b1;
    #1;
    chk("fl_stall_masked", 32'(stall), 0);
    tick();
    flush = 1'b0;
    setId(1'b0, ADD_B, 5'd0, 5'd0, 5'd0);
    chk("fl_ex_bubble", 32'({ex_regdst, ex_alusrc, ex_aluop, ex_dest}), 0);
    chk("fl_mem_bubble", 32'({mem_memread, mem_memwrite, mem_branch, mem_dest}), 0);
    chk("fl_wb_beq", 32'({wb_memtoreg, wb_regwrite, wb_dest}), 2);

    // sw propagation, then X on the bundle inputs with id_valid=0
    setId(1'b1, SW_B, 5'd3, 5'd16, 5'bx);
    tick();
    chk("sw_c1_memwrite", 32'(mem_memwrite), 0);
    setId(1'b0, 9'bx, 5'bx, 5'bx, 5'bx);
    chk("x_stall", 32'(stall), 0);
    tick();
    chk("sw_c2_memwrite", 32'(mem_memwrite), 1);
    chk("sw_c2_memread", 32'(mem_memread), 0);
    tick();
    chk("sw_c3_wb_regwrite", 32'(wb_regwrite), 0);
    chk("sw_c3_memwrite", 32'(mem_memwrite), 0);
    tick();
    chk("x_all_clean", 32'(allOut), 0);

    // Reset mid-stream discards in-flight bundles
    setId(1'b1, LW_B, 5'd1, 5'd8, 5'd0);
    tick();
    setId(1'b1, ADD_B, 5'd1, 5'd2, 5'd3);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_all", 32'(allOut), 0);
    rst = 1'b0;
    setId(1'b0, ADD_B, 5'd0, 5'd0, 5'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
